inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch initiator for the single-cycle-read instruction ROM (6-bit word address in, 32-bit instruction out, combinational).
- Owns the PC, drives the ROM address and registers the returned instruction into an IF/ID output stage with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute and flushes any wrong-path instruction.

Parameters:
- ADDR_W, 6, PC/ROM word-address width (ROM depth = 2**ADDR_W)
- INST_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of the retired-fetch counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rom_addr  out  ADDR_W  word address to instruction ROM, driven directly from the PC register
- rom_inst  in  INST_W  instruction returned combinationally by the ROM for rom_addr
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  ADDR_W  target word address for the redirect
- id_ready  in  1  decode can accept the IF/ID register this cycle
- if_valid  out  1  IF/ID register holds a valid instruction
- if_inst  out  INST_W  registered instruction
- if_pc  out  ADDR_W  word address if_inst was fetched from
- if_pc_next  out  ADDR_W  if_pc+1 mod 2**ADDR_W, used for link/branch base
- fetch_count  out  CNT_W  number of handshakes completed (if_valid && id_ready), saturating

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=BOOT
  - if_valid=0, if_inst=0, if_pc=0, if_pc_next=0, fetch_count=0
  - rom_addr follows pc, so it reads RESET_PC.
- FSM states: BOOT, RUN, HALTED (HALTED exists only with the optional feature).
  - BOOT: lasts exactly one cycle after reset release; no capture; next state RUN. A redirect in BOOT loads pc=redirect_pc, then goes to RUN.
  - RUN, advance condition: adv = !if_valid || id_ready.
  - RUN, if adv and no redirect: if_inst<=rom_inst, if_pc<=pc, if_pc_next<=pc+1, if_valid<=1, pc<=pc+1.
  - RUN, if !adv: pc and the IF/ID register hold; rom_addr stays stable.
- Redirect has the highest priority, in any state:
  - pc<=redirect_pc; if_valid<=0 next cycle (flush); nothing is captured that cycle.
  - Overrides stall: redirect with id_ready=0 still flushes.
  - A handshake occurring in the same cycle still counts toward fetch_count.
- PC arithmetic is modulo 2**ADDR_W: pc 63 -> 0; if_pc_next of 63 is 0.
- Fetch latency:
  - Instruction at address A appears on if_inst one cycle after pc=A with adv=1.
  - First valid instruction after reset appears 2 cycles after rst_n rises (BOOT + capture).
- fetch_count increments on every cycle with if_valid && id_ready and saturates at all-ones.
- Reset asserted mid-operation clears everything immediately; any redirect in flight is lost.

Optional Feature:
- Macro: INST_FETCH_HALT_EN
- With the macro:
  - A captured instruction with opcode bits [31:26]=6'b111111 is delivered normally (if_valid=1).
  - FSM then enters HALTED: pc frozen, no further captures; if_valid drops after that instruction handshakes.
  - Only redirect_valid (to RUN with the new pc) or reset leaves HALTED.
- Without the macro: opcode 6'b111111 is an ordinary instruction; HALTED state and its logic are absent.

Decomposition:
- Shared cpu package holds:
  - ADDR_W/INST_W defaults
  - opcode field position constants (OP_MSB=31, OP_LSB=26)
  - HALT opcode constant 6'b111111
  - fetch FSM state enum (BOOT, RUN, HALTED)
- One natural sub-module: if_id_reg (valid/ready pipeline register with flush), instantiated once; PC/FSM logic stays in inst_fetch.

Test Plan:
- Reset release, id_ready=1, ROM holds 0x00000000 at 0 and add at 1 -> if_valid=0 in BOOT; cycle 2 if_pc=0; cycle 3 if_pc=1, if_inst=0x00041083, if_pc_next=2.
- Hold id_ready=0 for 3 cycles after the first capture -> if_inst/if_pc unchanged, rom_addr stays 1, fetch_count unchanged; release -> sequence resumes at 1 with no skip or duplicate.
- redirect_valid=1, redirect_pc=0x05 while id_ready=0 and if_valid=1 -> next cycle if_valid=0; following cycle if_pc=5, if_inst=rom[5].
- Run pc to 63 with id_ready=1 -> if_pc 63 then 0; if_pc_next for 63 is 0.
- Assert rst_n=0 mid-stream, asynchronously between edges -> if_valid, fetch_count and if_pc clear immediately; rom_addr=RESET_PC.
- With INST_FETCH_HALT_EN, rom[3]=0xFC000000 -> address 3 delivered, then if_valid=0 and rom_addr frozen at 4; redirect to 0 restarts at 0. Without the macro -> fetch continues to 4.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared CPU front-end definitions used by the instruction-fetch block:
//   - default address/instruction widths
//   - opcode field position and the HALT opcode value
//   - fetch FSM state encoding
//   - is_halt_op(): opcode decode helper used when INST_FETCH_HALT_EN is defined
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int INST_W_DEF = 32;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;

   localparam logic [OP_MSB-OP_LSB:0] OP_HALT = 6'b111111;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   function automatic logic is_halt_op(input logic [INST_W_DEF-1:0] inst);
      return inst[OP_MSB:OP_LSB] == OP_HALT;
   endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// -----------------------------------------------------------------------------
// inst_fetch_if_id_reg
// IF/ID pipeline register with valid/ready handshake and flush.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            drop the held entry (takes priority over load)
//   load             capture in_* this cycle and mark the entry valid
//   ready            downstream accepts the held entry this cycle
//   in_inst/in_pc/in_pc_next  entry contents to capture
//   valid/inst/pc/pc_next     registered entry
// -----------------------------------------------------------------------------
module inst_fetch_if_id_reg #(
   parameter int ADDR_W = 6,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              load,
   input  logic              ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [ADDR_W-1:0] in_pc_next,
   output logic              valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next
);

   logic              valid_q, valid_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_next_q, pc_next_d;

   always_comb begin
      valid_d   = valid_q;
      inst_d    = inst_q;
      pc_d      = pc_q;
      pc_next_d = pc_next_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d   = 1'b1;
         inst_d    = in_inst;
         pc_d      = in_pc;
         pc_next_d = in_pc_next;
      end else if (ready) begin
         // Entry consumed with nothing behind it: becomes empty, data kept.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         inst_q    <= '0;
         pc_q      <= '0;
         pc_next_q <= '0;
      end else begin
         valid_q   <= valid_d;
         inst_q    <= inst_d;
         pc_q      <= pc_d;
         pc_next_q <= pc_next_d;
      end
   end

   assign valid   = valid_q;
   assign inst    = inst_q;
   assign pc      = pc_q;
   assign pc_next = pc_next_q;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch initiator for a combinational-read instruction ROM.
// Owns the PC, drives rom_addr straight from it, captures rom_inst into an
// IF/ID register handshaking with decode, and takes redirects from execute.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rom_addr/rom_inst   ROM word address out, instruction back (same cycle)
//   redirect_valid/pc   execute-side PC change; flushes the IF/ID entry
//   id_ready            decode accepts the IF/ID entry this cycle
//   if_valid/if_inst/if_pc/if_pc_next   IF/ID register toward decode
//   fetch_count         saturating count of completed handshakes
// Optional feature: define INST_FETCH_HALT_EN to stop fetching after an
// instruction whose opcode [31:26] is 6'b111111 (HALTED state); only a
// redirect or reset resumes fetch.
// -----------------------------------------------------------------------------
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INST_W   = INST_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              id_ready,
   output logic              if_valid,
   output logic [INST_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_next,
   output logic [CNT_W-1:0]  fetch_count
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              adv;
   logic              handshake;
   logic              load;
   logic              flush;

   // Wraps naturally at 2**ADDR_W.
   assign pc_inc    = pc_q + ADDR_W'(1);
   assign adv       = !if_valid || id_ready;
   assign handshake = if_valid && id_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load    = 1'b0;
      flush   = 1'b0;
      if (redirect_valid) begin
         // Redirect wins over stall, boot and halt; the current entry is wrong-path.
         pc_d    = redirect_pc;
         state_d = ST_RUN;
         flush   = 1'b1;
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (adv) begin
                  load = 1'b1;
                  pc_d = pc_inc;
`ifdef INST_FETCH_HALT_EN
                  if (is_halt_op(rom_inst)) begin
                     state_d = ST_HALTED;
                  end
`endif
               end
            end
`ifdef INST_FETCH_HALT_EN
            ST_HALTED: begin
               state_d = ST_HALTED;
            end
`endif
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (handshake && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   inst_fetch_if_id_reg #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (load),
      .ready      (id_ready),
      .in_inst    (rom_inst),
      .in_pc      (pc_q),
      .in_pc_next (pc_inc),
      .valid      (if_valid),
      .inst       (if_inst),
      .pc         (if_pc),
      .pc_next    (if_pc_next)
   );

   assign rom_addr    = pc_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   localparam int ADDR_W = 6;
   localparam int INST_W = 32;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_inst;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
   logic              id_ready = 1'b0;
   logic              if_valid;
   logic [INST_W-1:0] if_inst;
   logic [ADDR_W-1:0] if_pc;
   logic [ADDR_W-1:0] if_pc_next;
   logic [CNT_W-1:0]  fetch_count;

   logic [INST_W-1:0] rom [64];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign rom_inst = rom[rom_addr];

   inst_fetch #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .RESET_PC (6'd0),
      .CNT_W    (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_inst       (rom_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_pc_next     (if_pc_next),
      .fetch_count    (fetch_count)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hold reset two cycles, release on a falling edge.
   task automatic do_reset(input logic rdy);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = rdy;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      n_cmp++;
      if (if_valid !== 1'b0 || rom_addr !== 6'd0 || fetch_count !== 4'd0 || if_inst !== 32'h0 || if_pc !== 6'd0 || if_pc_next !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_state: valid=%b addr=%0d cnt=%0d inst=%h pc=%0d pcn=%0d, required 0 0 0 0 0 0", if_valid, rom_addr, fetch_count, if_inst, if_pc, if_pc_next);
      end
      tick();
      n_cmp++;
      if (if_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL boot_no_capture: valid=%b, required 0", if_valid);
      end
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd0 || if_inst !== 32'h0 || if_pc_next !== 6'd1) begin
         n_bad++;
         $display("FAIL first_fetch: valid=%b pc=%0d inst=%h pcn=%0d, required 1 0 00000000 1", if_valid, if_pc, if_inst, if_pc_next);
      end
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd1 || if_inst !== 32'h00041083 || if_pc_next !== 6'd2 || fetch_count !== 4'd1) begin
         n_bad++;
         $display("FAIL second_fetch: valid=%b pc=%0d inst=%h pcn=%0d cnt=%0d, required 1 1 00041083 2 1", if_valid, if_pc, if_inst, if_pc_next, fetch_count);
      end
   endtask

   task automatic test_stall();
      do_reset(1'b0);
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (if_valid !== 1'b1 || if_pc !== 6'd0 || if_inst !== 32'h0 || rom_addr !== 6'd1 || fetch_count !== 4'd0) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: valid=%b pc=%0d inst=%h addr=%0d cnt=%0d, required 1 0 00000000 1 0", i, if_valid, if_pc, if_inst, rom_addr, fetch_count);
         end
      end
      id_ready = 1'b1;
      tick();
      n_cmp++;
      if (if_pc !== 6'd1 || if_inst !== 32'h00041083 || fetch_count !== 4'd1) begin
         n_bad++;
         $display("FAIL stall_resume: pc=%0d inst=%h cnt=%0d, required 1 00041083 1", if_pc, if_inst, fetch_count);
      end
      tick();
      n_cmp++;
      if (if_pc !== 6'd2 || if_inst !== 32'hA5000002 || fetch_count !== 4'd2) begin
         n_bad++;
         $display("FAIL stall_next: pc=%0d inst=%h cnt=%0d, required 2 a5000002 2", if_pc, if_inst, fetch_count);
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b1);
      tick();
      tick();
      // Redirect while stalled: flush, no handshake counted.
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 6'd5;
      tick();
      n_cmp++;
      if (if_valid !== 1'b0 || rom_addr !== 6'd5 || fetch_count !== 4'd0) begin
         n_bad++;
         $display("FAIL redirect_flush: valid=%b addr=%0d cnt=%0d, required 0 5 0", if_valid, rom_addr, fetch_count);
      end
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd5 || if_inst !== 32'hA5000005) begin
         n_bad++;
         $display("FAIL redirect_target: valid=%b pc=%0d inst=%h, required 1 5 a5000005", if_valid, if_pc, if_inst);
      end
      // Redirect with a handshake in the same cycle: still counted.
      redirect_valid = 1'b1;
      redirect_pc    = 6'd10;
      tick();
      n_cmp++;
      if (if_valid !== 1'b0 || fetch_count !== 4'd1 || rom_addr !== 6'd10) begin
         n_bad++;
         $display("FAIL redirect_handshake: valid=%b cnt=%0d addr=%0d, required 0 1 10", if_valid, fetch_count, rom_addr);
      end
      redirect_valid = 1'b0;
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd10 || fetch_count !== 4'd1) begin
         n_bad++;
         $display("FAIL redirect_resume: valid=%b pc=%0d cnt=%0d, required 1 10 1", if_valid, if_pc, fetch_count);
      end
      // Redirect presented during BOOT.
      do_reset(1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 6'd20;
      tick();
      n_cmp++;
      if (if_valid !== 1'b0 || rom_addr !== 6'd20) begin
         n_bad++;
         $display("FAIL redirect_boot: valid=%b addr=%0d, required 0 20", if_valid, rom_addr);
      end
      redirect_valid = 1'b0;
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd20 || if_inst !== 32'hA5000014) begin
         n_bad++;
         $display("FAIL redirect_boot_fetch: valid=%b pc=%0d inst=%h, required 1 20 a5000014", if_valid, if_pc, if_inst);
      end
   endtask

   task automatic test_wrap();
      do_reset(1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 6'd62;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_cmp++;
      if (if_pc !== 6'd62 || if_pc_next !== 6'd63) begin
         n_bad++;
         $display("FAIL wrap_62: pc=%0d pcn=%0d, required 62 63", if_pc, if_pc_next);
      end
      tick();
      n_cmp++;
      if (if_pc !== 6'd63 || if_pc_next !== 6'd0 || rom_addr !== 6'd0 || if_inst !== 32'hA500003F) begin
         n_bad++;
         $display("FAIL wrap_63: pc=%0d pcn=%0d addr=%0d inst=%h, required 63 0 0 a500003f", if_pc, if_pc_next, rom_addr, if_inst);
      end
      tick();
      n_cmp++;
      if (if_pc !== 6'd0 || if_pc_next !== 6'd1 || if_inst !== 32'h0) begin
         n_bad++;
         $display("FAIL wrap_0: pc=%0d pcn=%0d inst=%h, required 0 1 00000000", if_pc, if_pc_next, if_inst);
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 6'd33;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (if_valid !== 1'b0 || fetch_count !== 4'd0 || if_pc !== 6'd0 || rom_addr !== 6'd0 || if_inst !== 32'h0) begin
         n_bad++;
         $display("FAIL async_reset: valid=%b cnt=%0d pc=%0d addr=%0d inst=%h, required 0 0 0 0 0", if_valid, fetch_count, if_pc, rom_addr, if_inst);
      end
      redirect_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd0) begin
         n_bad++;
         $display("FAIL async_reset_restart: valid=%b pc=%0d, required 1 0", if_valid, if_pc);
      end
   endtask

   task automatic test_saturation();
      do_reset(1'b1);
      for (int k = 1; k <= 16; k++) tick();
      n_cmp++;
      if (fetch_count !== 4'd14) begin
         n_bad++;
         $display("FAIL count_pre_sat: cnt=%0d, required 14", fetch_count);
      end
      tick();
      n_cmp++;
      if (fetch_count !== 4'd15) begin
         n_bad++;
         $display("FAIL count_at_sat: cnt=%0d, required 15", fetch_count);
      end
      for (int k = 0; k < 3; k++) tick();
      n_cmp++;
      if (fetch_count !== 4'd15) begin
         n_bad++;
         $display("FAIL count_saturated: cnt=%0d, required 15", fetch_count);
      end
   endtask

   task automatic test_halt();
      rom[3] = 32'hFC000000;
      do_reset(1'b1);
      for (int k = 0; k < 5; k++) tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd3 || if_inst !== 32'hFC000000 || rom_addr !== 6'd4) begin
         n_bad++;
         $display("FAIL halt_deliver: valid=%b pc=%0d inst=%h addr=%0d, required 1 3 fc000000 4", if_valid, if_pc, if_inst, rom_addr);
      end
      tick();
      tick();
`ifdef INST_FETCH_HALT_EN
      n_cmp++;
      if (if_valid !== 1'b0 || rom_addr !== 6'd4) begin
         n_bad++;
         $display("FAIL halt_frozen: valid=%b addr=%0d, required 0 4", if_valid, rom_addr);
      end
`else
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd5 || rom_addr !== 6'd6) begin
         n_bad++;
         $display("FAIL halt_ignored: valid=%b pc=%0d addr=%0d, required 1 5 6", if_valid, if_pc, rom_addr);
      end
`endif
      redirect_valid = 1'b1;
      redirect_pc    = 6'd0;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 6'd0 || rom_addr !== 6'd1) begin
         n_bad++;
         $display("FAIL halt_restart: valid=%b pc=%0d addr=%0d, required 1 0 1", if_valid, if_pc, rom_addr);
      end
      rom[3] = 32'hA5000003;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'hA5000000 | 32'(i);
      rom[0] = 32'h00000000;
      rom[1] = 32'h00041083;
      test_reset();
      test_stall();
      test_redirect();
      test_wrap();
      test_async_reset();
      test_saturation();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
